pcm_rom_cache: RTL and testbench
================================

PCM_ROM_CACHE -- requirements
Module: pcm_rom_cache

Interface
REQ-001 SHALL have parameter LINES, default 4, number of direct-mapped 64-bit lines (power of two, 2..16).
REQ-002 SHALL have port clk_sys  input  1  system clock (96 MHz); all logic on its rising edge.
REQ-003 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port rd_req  input  1  single-cycle PCM byte read strobe from the sound core.
REQ-005 SHALL have port rd_addr  input  18  PCM ROM byte address, sampled when rd_req=1.
REQ-006 SHALL have port rd_data  output  8  returned byte, valid while rd_ready=1 and held until the next response.
REQ-007 SHALL have port rd_ready  output  1  single-cycle response pulse.
REQ-008 SHALL have port busy  output  1  high from an accepted rd_req until its rd_ready, inclusive.
REQ-009 SHALL have port ddr_req  output  1  single-cycle fetch pulse to the DDRAM channel.
REQ-010 SHALL have port ddr_addr  output  18  fetch byte address; [2:0] always 0; held stable from ddr_req until ddr_ready.
REQ-011 SHALL have port ddr_ready  input  1  single-cycle fetch completion pulse.
REQ-012 SHALL have port ddr_data  input  64  fetched word, valid only in the ddr_ready cycle; byte n = bits [8n+7:8n].
REQ-013 SHALL have port invalidate  input  1  clears all lines (driven by ROM download active).

Function
REQ-014 Address split: offset=rd_addr[2:0]; index=rd_addr[2+log2(LINES):3]; tag=rd_addr[17:3+log2(LINES)].
REQ-015 SHALL implement FSM states IDLE, FETCH, RESPOND.
REQ-016 IDLE + rd_req: latch rd_addr; hit (valid and tag match) -> RESPOND; miss -> FETCH with ddr_req=1 in the following cycle.
REQ-017 Hit latency: rd_ready exactly 1 cycle after rd_req.
REQ-018 FETCH: wait indefinitely for ddr_ready; on ddr_ready write line data, tag and valid, then go to RESPOND.
REQ-019 Miss latency: rd_ready exactly 1 cycle after ddr_ready.
REQ-020 RESPOND: rd_ready=1 and rd_data=byte[offset] of the line for one cycle, then IDLE.
REQ-021 rd_req while busy=1 SHALL be ignored: no state change and no extra response.
REQ-022 ddr_ready outside FETCH SHALL be ignored.
REQ-023 invalidate=1 SHALL clear every valid bit in the same cycle and SHALL take priority over a line write.
REQ-024 invalidate during FETCH: fetch completes and the byte is returned, but the line stays invalid.
REQ-025 invalidate with rd_req in IDLE: lookup treated as a miss.
REQ-026 Exactly one outstanding ddr_req at any time; ddr_req never asserted outside the IDLE->FETCH transition.

Reset
REQ-027 reset_n=0 SHALL asynchronously force state IDLE, all valid bits 0, rd_ready=0, busy=0, ddr_req=0, ddr_addr=0, rd_data=0.
REQ-028 Reset mid-FETCH SHALL abandon the fetch; the first ddr_ready after release SHALL be ignored per REQ-022.
REQ-029 Line data and tag storage need not be reset.

Structure
REQ-030 Package pcm_rom_cache_pkg SHALL hold the state enum, address width 18, line width 64, and the index/tag width functions of LINES.
REQ-031 One sub-module pcm_line_store SHALL hold the data/tag array with a registered write and combinational read; valid bits stay in the parent.

Verification
REQ-032 Cold read: rd_req addr 0x00005 -> ddr_req with ddr_addr 0x00000; ddr_ready data 0x8877665544332211 -> rd_ready 1 cycle later, rd_data 0x66.
REQ-033 Hit: then rd_req addr 0x00007 -> rd_ready next cycle, rd_data 0x88, no ddr_req.
REQ-034 Conflict (LINES=4): read 0x00020 then 0x00000 -> second access misses and issues ddr_req with ddr_addr 0x00000.
REQ-035 invalidate pulse coinciding with ddr_ready -> byte returned; repeat read of same address issues a new ddr_req.
REQ-036 rd_req during FETCH and stray ddr_ready in IDLE -> ignored; exactly one rd_ready per accepted request.
REQ-037 reset_n low 2 cycles mid-FETCH -> all outputs 0; next read of the previously fetched address misses.

Source files
------------

// File: rtl/pcm_rom_cache_pkg.sv
// Shared types and address-geometry helpers for the PCM ROM line cache.
// Geometry depends on LINES, the number of direct-mapped 64-bit lines.
package pcm_rom_cache_pkg;

    localparam int unsigned ADDR_W = 18;
    localparam int unsigned LINE_W = 64;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned OFF_W  = 3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_FETCH   = 2'd1,
        ST_RESPOND = 2'd2
    } state_t;

    // Index and tag widths follow from the line count.
    function automatic int unsigned idx_w(input int unsigned lines);
        return $clog2(lines);
    endfunction

    function automatic int unsigned tag_w(input int unsigned lines);
        return ADDR_W - OFF_W - idx_w(lines);
    endfunction

    // Little-endian byte pick: byte n sits in bits [8n+7:8n].
    function automatic logic [BYTE_W-1:0] line_byte(input logic [LINE_W-1:0] line,
                                                    input logic [OFF_W-1:0]  off);
        return line[{off, 3'b000} +: BYTE_W];
    endfunction

endpackage

// File: rtl/pcm_line_store.sv
// Data/tag array for the PCM cache.
// A write is registered on the clock edge; the read is combinational.
module pcm_line_store
    import pcm_rom_cache_pkg::*;
#(
    parameter  int unsigned LINES = 4,
    localparam int unsigned IDX_W = idx_w(LINES),
    localparam int unsigned TAG_W = tag_w(LINES)
) (
    input  logic              clk_sys,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_index,
    input  logic [TAG_W-1:0]  wr_tag,
    input  logic [LINE_W-1:0] wr_line,
    input  logic [IDX_W-1:0]  rd_index,
    output logic [TAG_W-1:0]  rd_tag,
    output logic [LINE_W-1:0] rd_line
);

    logic [LINE_W-1:0] line_mem [LINES];
    logic [TAG_W-1:0]  tag_mem  [LINES];

    // Storage holds no reset state; the parent's valid bits gate every use.
    always_ff @(posedge clk_sys) begin
        if (wr_en) begin
            line_mem[wr_index] <= wr_line;
            tag_mem[wr_index]  <= wr_tag;
        end
    end

    always_comb begin
        rd_tag  = tag_mem[rd_index];
        rd_line = line_mem[rd_index];
    end

endmodule

// File: rtl/pcm_rom_cache.sv
// Direct-mapped byte-read cache in front of the PCM ROM image in DDRAM.
// A hit responds one cycle after the request. A miss fetches one 64-bit line.
module pcm_rom_cache
    import pcm_rom_cache_pkg::*;
#(
    parameter int unsigned LINES = 4
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [BYTE_W-1:0] rd_data,
    output logic              rd_ready,
    output logic              busy,
    output logic              ddr_req,
    output logic [ADDR_W-1:0] ddr_addr,
    input  logic              ddr_ready,
    input  logic [LINE_W-1:0] ddr_data,
    input  logic              invalidate
);

    localparam int unsigned IDX_W = idx_w(LINES);
    localparam int unsigned TAG_W = tag_w(LINES);

    state_t            state;
    logic [ADDR_W-1:0] req_addr;
    logic [LINES-1:0]  valid;

    logic [IDX_W-1:0]  lookup_index_c;
    logic [TAG_W-1:0]  lookup_tag_c;
    logic [IDX_W-1:0]  fill_index_c;
    logic [TAG_W-1:0]  fill_tag_c;
    logic [TAG_W-1:0]  line_tag_c;
    logic [LINE_W-1:0] line_data_c;
    logic              hit_c;
    logic              fill_c;

    always_comb begin
        lookup_index_c = rd_addr[OFF_W +: IDX_W];
        lookup_tag_c   = rd_addr[ADDR_W-1 -: TAG_W];
        fill_index_c   = req_addr[OFF_W +: IDX_W];
        fill_tag_c     = req_addr[ADDR_W-1 -: TAG_W];
        // A concurrent invalidate forces a miss so no stale line is served.
        hit_c          = valid[lookup_index_c] && (line_tag_c == lookup_tag_c) && !invalidate;
        fill_c         = (state == ST_FETCH) && ddr_ready;
    end

    pcm_line_store #(
        .LINES (LINES)
    ) u_line_store (
        .clk_sys  (clk_sys),
        .wr_en    (fill_c),
        .wr_index (fill_index_c),
        .wr_tag   (fill_tag_c),
        .wr_line  (ddr_data),
        .rd_index (lookup_index_c),
        .rd_tag   (line_tag_c),
        .rd_line  (line_data_c)
    );

    // Invalidate wins over a fill, leaving the just-written line unusable.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            valid <= '0;
        end else if (invalidate) begin
            valid <= '0;
        end else if (fill_c) begin
            valid[fill_index_c] <= 1'b1;
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            req_addr <= '0;
            rd_data  <= '0;
            rd_ready <= 1'b0;
            busy     <= 1'b0;
            ddr_req  <= 1'b0;
            ddr_addr <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (rd_req) begin
                        req_addr <= rd_addr;
                        busy     <= 1'b1;
                        if (hit_c) begin
                            state    <= ST_RESPOND;
                            rd_ready <= 1'b1;
                            rd_data  <= line_byte(line_data_c, rd_addr[OFF_W-1:0]);
                        end else begin
                            state    <= ST_FETCH;
                            ddr_req  <= 1'b1;
                            ddr_addr <= {rd_addr[ADDR_W-1:OFF_W], OFF_W'(0)};
                        end
                    end
                end

                ST_FETCH: begin
                    ddr_req <= 1'b0;
                    if (ddr_ready) begin
                        state    <= ST_RESPOND;
                        rd_ready <= 1'b1;
                        rd_data  <= line_byte(ddr_data, req_addr[OFF_W-1:0]);
                    end
                end

                ST_RESPOND: begin
                    state    <= ST_IDLE;
                    rd_ready <= 1'b0;
                    busy     <= 1'b0;
                end

                default: begin
                    state    <= ST_IDLE;
                    rd_ready <= 1'b0;
                    busy     <= 1'b0;
                    ddr_req  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pcm_rom_cache.sv
// Directed bench for pcm_rom_cache: expected bytes queue on each accepted
// request and are matched against every rd_ready pulse.
module tb_pcm_rom_cache;

    logic        clk_sys = 1'b0;
    logic        reset_n = 1'b0;
    logic        rd_req = 1'b0;
    logic [17:0] rd_addr = '0;
    logic [7:0]  rd_data;
    logic        rd_ready;
    logic        busy;
    logic        ddr_req;
    logic [17:0] ddr_addr;
    logic        ddr_ready = 1'b0;
    logic [63:0] ddr_data = '0;
    logic        invalidate = 1'b0;

    int total = 0;
    int bad   = 0;
    logic [7:0] sb [$];

    localparam logic [63:0] W0 = 64'h8877665544332211;
    localparam logic [63:0] W1 = 64'h0102030405060708;
    localparam logic [63:0] W2 = 64'hF0E0D0C0B0A09080;
    localparam logic [63:0] W3 = 64'hDEADBEEFCAFEF00D;
    localparam logic [63:0] W4 = 64'h1122334455667788;

    pcm_rom_cache #(.LINES(4)) dut (
        .clk_sys    (clk_sys),
        .reset_n    (reset_n),
        .rd_req     (rd_req),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .rd_ready   (rd_ready),
        .busy       (busy),
        .ddr_req    (ddr_req),
        .ddr_addr   (ddr_addr),
        .ddr_ready  (ddr_ready),
        .ddr_data   (ddr_data),
        .invalidate (invalidate)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Every response must match the oldest outstanding expectation.
    always @(negedge clk_sys) begin
        if (rd_ready === 1'b1) begin
            if (sb.size() == 0) begin
                check("spurious_ready", 64'(sb.size()), 64'd1);
            end else begin
                check("rd_data", 64'(rd_data), 64'(sb.pop_front()));
            end
        end
    end

    task automatic check_idle_outputs(input string tag);
        check({tag, "_rd_ready"}, 64'(rd_ready), 64'd0);
        check({tag, "_busy"},     64'(busy),     64'd0);
        check({tag, "_ddr_req"},  64'(ddr_req),  64'd0);
        check({tag, "_ddr_addr"}, 64'(ddr_addr), 64'd0);
        check({tag, "_rd_data"},  64'(rd_data),  64'd0);
    endtask

    task automatic hit_read(input logic [17:0] a, input logic [7:0] e);
        rd_addr = a;
        rd_req  = 1'b1;
        sb.push_back(e);
        @(negedge clk_sys);
        rd_req = 1'b0;
        check("hit_ready",  64'(rd_ready), 64'd1);
        check("hit_busy",   64'(busy),     64'd1);
        check("hit_no_ddr", 64'(ddr_req),  64'd0);
        @(negedge clk_sys);
        check("hit_ready_drop", 64'(rd_ready), 64'd0);
        check("hit_busy_drop",  64'(busy),     64'd0);
        check("hit_data_held",  64'(rd_data),  64'(e));
    endtask

    task automatic miss_read(input logic [17:0] a, input logic [63:0] w, input logic [7:0] e,
                             input logic inv_req, input logic inv_ready);
        rd_addr    = a;
        rd_req     = 1'b1;
        invalidate = inv_req;
        sb.push_back(e);
        @(negedge clk_sys);
        rd_req     = 1'b0;
        invalidate = 1'b0;
        check("miss_ddr_req",  64'(ddr_req),  64'd1);
        check("miss_ddr_addr", 64'(ddr_addr), 64'(a & 18'h3FFF8));
        check("miss_no_ready", 64'(rd_ready), 64'd0);
        check("miss_busy",     64'(busy),     64'd1);
        @(negedge clk_sys);
        check("miss_req_pulse", 64'(ddr_req), 64'd0);
        check("miss_addr_hold", 64'(ddr_addr), 64'(a & 18'h3FFF8));
        ddr_ready  = 1'b1;
        ddr_data   = w;
        invalidate = inv_ready;
        @(negedge clk_sys);
        ddr_ready  = 1'b0;
        ddr_data   = '0;
        invalidate = 1'b0;
        check("miss_ready", 64'(rd_ready), 64'd1);
        check("miss_busy_resp", 64'(busy), 64'd1);
        @(negedge clk_sys);
        check("miss_ready_drop", 64'(rd_ready), 64'd0);
        check("miss_busy_drop",  64'(busy),     64'd0);
    endtask

    initial begin
        #200us;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        repeat (2) @(negedge clk_sys);
        check_idle_outputs("reset");
        reset_n = 1'b1;
        @(negedge clk_sys);
        check_idle_outputs("post_reset");

        // Cold miss, hit in the same line, then a same-index conflict.
        miss_read(18'h00005, W0, 8'h66, 1'b0, 1'b0);
        hit_read (18'h00007, 8'h88);
        miss_read(18'h00020, W1, 8'h08, 1'b0, 1'b0);
        miss_read(18'h00000, W0, 8'h11, 1'b0, 1'b0);
        miss_read(18'h0000B, W2, 8'hB0, 1'b0, 1'b0);
        hit_read (18'h0000E, 8'hE0);
        hit_read (18'h00003, 8'h44);

        // Invalidate coinciding with the fill: byte returned, line stays invalid.
        miss_read(18'h00100, W3, 8'h0D, 1'b0, 1'b1);
        miss_read(18'h00100, W3, 8'h0D, 1'b0, 1'b0);
        hit_read (18'h00101, 8'hF0);
        miss_read(18'h0000B, W2, 8'hB0, 1'b0, 1'b0);

        // Requests while busy and a stray ddr_ready in IDLE are ignored.
        rd_addr = 18'h00200;
        rd_req  = 1'b1;
        sb.push_back(8'h88);
        @(negedge clk_sys);
        rd_addr = 18'h00101;
        check("busy_fetch_req", 64'(ddr_req), 64'd1);
        @(negedge clk_sys);
        rd_req = 1'b0;
        check("busy_no_rereq", 64'(ddr_req),  64'd0);
        check("busy_no_ready", 64'(rd_ready), 64'd0);
        check("busy_high",     64'(busy),     64'd1);
        @(negedge clk_sys);
        check("busy_still_wait", 64'(rd_ready), 64'd0);
        check("busy_addr",       64'(ddr_addr), 64'h200);
        ddr_ready = 1'b1;
        ddr_data  = W4;
        @(negedge clk_sys);
        ddr_ready = 1'b0;
        check("busy_resp", 64'(rd_ready), 64'd1);
        rd_addr = 18'h00101;
        rd_req  = 1'b1;
        @(negedge clk_sys);
        rd_req = 1'b0;
        check("respond_req_ignored", 64'(rd_ready), 64'd0);
        check("respond_busy_drop",   64'(busy),     64'd0);
        ddr_ready = 1'b1;
        ddr_data  = 64'hFFFF_FFFF_FFFF_FFFF;
        @(negedge clk_sys);
        ddr_ready = 1'b0;
        ddr_data  = '0;
        check("stray_no_ready", 64'(rd_ready), 64'd0);
        check("stray_no_busy",  64'(busy),     64'd0);
        check("stray_no_req",   64'(ddr_req),  64'd0);
        hit_read(18'h00201, 8'h77);

        // Invalidate alongside a request forces a miss.
        miss_read(18'h00201, W4, 8'h77, 1'b1, 1'b0);
        hit_read (18'h00207, 8'h11);

        // Reset mid-fetch abandons it and clears all lines.
        rd_addr = 18'h00300;
        rd_req  = 1'b1;
        @(negedge clk_sys);
        rd_req = 1'b0;
        check("rst_fetch_req", 64'(ddr_req), 64'd1);
        reset_n = 1'b0;
        #1;
        check_idle_outputs("async_reset");
        repeat (2) @(negedge clk_sys);
        check_idle_outputs("held_reset");
        reset_n = 1'b1;
        @(negedge clk_sys);
        ddr_ready = 1'b1;
        ddr_data  = W3;
        @(negedge clk_sys);
        ddr_ready = 1'b0;
        ddr_data  = '0;
        check("post_rst_stray_ready", 64'(rd_ready), 64'd0);
        check("post_rst_stray_busy",  64'(busy),     64'd0);
        miss_read(18'h00201, W4, 8'h77, 1'b0, 1'b0);

        @(negedge clk_sys);
        check("sb_drained", 64'(sb.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
